// File: rtl/sdram_user_port_pkg.sv
// Shared sizes, FSM encodings and the arbitration decision for the SDRAM user port.
// Default sizes mirror the SDR_SDRAM_* widths of the 16-bit controller.
package sdram_user_port_pkg;

  localparam int DEF_DATA_SZ    = 16;  // SDR_SDRAM_DATA_WIDTH
  localparam int DEF_ADDR_SZ    = 22;  // SDR_SDRAM_ROW_SIZE + SDR_SDRAM_COL_SIZE
  localparam int DEF_WF_DEPTH   = 8;
  localparam int DEF_WF_HI_WM   = 6;
  localparam int DEF_MAX_RD_OUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_REQ = 2'd1,
    ST_RD_REQ = 2'd2
  } arb_state_e;

  typedef enum logic {
    LAST_WR = 1'b0,
    LAST_RD = 1'b1
  } last_gnt_e;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_WR   = 2'd1,
    DEC_RD   = 2'd2
  } arb_dec_e;

  // High watermark beats fairness; otherwise alternate away from the last granted type.
  function automatic arb_dec_e arb_pick(input logic wr_elig, input logic rd_elig,
                                        input logic hi_wm, input last_gnt_e last);
    arb_dec_e dec;
    dec = DEC_NONE;
    if (wr_elig && hi_wm) begin
      dec = DEC_WR;
    end else if (wr_elig && rd_elig) begin
      if (last == LAST_WR) dec = DEC_RD;
      else                 dec = DEC_WR;
    end else if (wr_elig) begin
      dec = DEC_WR;
    end else if (rd_elig) begin
      dec = DEC_RD;
    end
    return dec;
  endfunction

endpackage

// File: rtl/sdram_user_port_wr_fifo.sv
// Synchronous write FIFO holding {addr,data} entries; head is valid whenever not empty.
// Occupancy is kept as an explicit level register so full/empty/level are all registered.
module sdram_wr_fifo #(
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (PW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign {head_addr, head_data} = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers are PW bits wide, so increments wrap modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

endmodule

// File: rtl/sdram_user_port.sv
// Client front-end of the SDRAM controller: write FIFO plus one read slot, arbitrated
// into a single in-flight wr_req/rd_req handshake, with registered read-data return.
module sdram_user_port
  import sdram_user_port_pkg::*;
#(
  parameter int DATA_SZ    = DEF_DATA_SZ,
  parameter int ADDR_SZ    = DEF_ADDR_SZ,
  parameter int WF_DEPTH   = DEF_WF_DEPTH,
  parameter int WF_HI_WM   = DEF_WF_HI_WM,
  parameter int MAX_RD_OUT = DEF_MAX_RD_OUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        u_wr_valid,
  output logic                        u_wr_ready,
  input  logic [ADDR_SZ-1:0]          u_wr_addr,
  input  logic [DATA_SZ-1:0]          u_wr_data,
  input  logic                        u_rd_valid,
  output logic                        u_rd_ready,
  input  logic [ADDR_SZ-1:0]          u_rd_addr,
  output logic [DATA_SZ-1:0]          u_rdata,
  output logic                        u_rdata_valid,
  output logic [$clog2(WF_DEPTH):0]   wf_level,
  output logic                        wr_req,
  input  logic                        wr_gnt,
  output logic [ADDR_SZ-1:0]          wr_addr,
  output logic [DATA_SZ-1:0]          wr_data,
  output logic                        rd_req,
  input  logic                        rd_gnt,
  output logic [ADDR_SZ-1:0]          rd_addr,
  input  logic [DATA_SZ-1:0]          rd_data,
  input  logic                        rd_valid,
  output arb_state_e                  dbg_state
);

  // Handshakes: a client beat transfers on valid&ready at a rising edge. A controller
  // request (req + payload) is registered and held until the edge that samples gnt
  // high; req drops at that same edge. gnt outside a matching request is ignored.

  localparam int LVL_W = $clog2(WF_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_RD_OUT + 1);

  arb_state_e          state_q, state_d;
  last_gnt_e           last_q, last_d;
  logic                wr_req_q, wr_req_d;
  logic [ADDR_SZ-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_SZ-1:0]  wr_data_q, wr_data_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_SZ-1:0]  rd_addr_q, rd_addr_d;
  logic                slot_valid_q, slot_valid_d;
  logic [ADDR_SZ-1:0]  slot_addr_q, slot_addr_d;
  logic [OUT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [DATA_SZ-1:0]  u_rdata_q, u_rdata_d;
  logic                u_rdata_valid_q, u_rdata_valid_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_SZ-1:0]  fifo_head_addr;
  logic [DATA_SZ-1:0]  fifo_head_data;
  logic [LVL_W-1:0]    fifo_level;
  logic                rd_take, wr_elig, rd_elig, hi_wm;
  arb_dec_e            dec;

  assign fifo_push = u_wr_valid && u_wr_ready;

  sdram_wr_fifo #(
    .AW    (ADDR_SZ),
    .DW    (DATA_SZ),
    .DEPTH (WF_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_addr (u_wr_addr),
    .push_data (u_wr_data),
    .pop       (fifo_pop),
    .head_addr (fifo_head_addr),
    .head_data (fifo_head_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_elig = !fifo_empty;
  assign rd_elig = slot_valid_q && (out_cnt_q < OUT_W'(MAX_RD_OUT));
  assign hi_wm   = (fifo_level >= LVL_W'(WF_HI_WM));
  assign dec     = arb_pick(wr_elig, rd_elig, hi_wm, last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    fifo_pop  = 1'b0;
    rd_take   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dec == DEC_WR) begin
          state_d   = ST_WR_REQ;
          wr_req_d  = 1'b1;
          wr_addr_d = fifo_head_addr;
          wr_data_d = fifo_head_data;
        end else if (dec == DEC_RD) begin
          state_d   = ST_RD_REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = slot_addr_q;
        end
      end
      ST_WR_REQ: begin
        if (wr_gnt) begin
          state_d  = ST_IDLE;
          wr_req_d = 1'b0;
          fifo_pop = 1'b1;
          last_d   = LAST_WR;
        end
      end
      ST_RD_REQ: begin
        if (rd_gnt) begin
          state_d  = ST_IDLE;
          rd_req_d = 1'b0;
          rd_take  = 1'b1;
          last_d   = LAST_RD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Read slot refills only while empty, so it can never be loaded on the grant edge.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    if (rd_take) slot_valid_d = 1'b0;
    if (u_rd_valid && !slot_valid_q) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = u_rd_addr;
    end
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    unique case ({rd_take, rd_valid})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   if (out_cnt_q != '0) out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    u_rdata_valid_d = rd_valid;
    u_rdata_d       = rd_valid ? rd_data : u_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_q          <= LAST_WR;
      wr_req_q        <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      rd_req_q        <= 1'b0;
      rd_addr_q       <= '0;
      slot_valid_q    <= 1'b0;
      slot_addr_q     <= '0;
      out_cnt_q       <= '0;
      u_rdata_q       <= '0;
      u_rdata_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      wr_req_q        <= wr_req_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      rd_req_q        <= rd_req_d;
      rd_addr_q       <= rd_addr_d;
      slot_valid_q    <= slot_valid_d;
      slot_addr_q     <= slot_addr_d;
      out_cnt_q       <= out_cnt_d;
      u_rdata_q       <= u_rdata_d;
      u_rdata_valid_q <= u_rdata_valid_d;
    end
  end

  assign u_wr_ready    = !fifo_full;
  assign u_rd_ready    = !slot_valid_q;
  assign wf_level      = fifo_level;
  assign wr_req        = wr_req_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_req        = rd_req_q;
  assign rd_addr       = rd_addr_q;
  assign u_rdata       = u_rdata_q;
  assign u_rdata_valid = u_rdata_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sdram_user_port.sv
// Directed bench for sdram_user_port: a vector table of single transactions plus
// hand-written sequences for FIFO full, interleaving, watermark, read limit and reset.
module tb_sdram_user_port;
  import sdram_user_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        u_wr_valid = 1'b0, u_wr_ready;
  logic [21:0] u_wr_addr = '0;
  logic [15:0] u_wr_data = '0;
  logic        u_rd_valid = 1'b0, u_rd_ready;
  logic [21:0] u_rd_addr = '0;
  logic [15:0] u_rdata;
  logic        u_rdata_valid;
  logic [3:0]  wf_level;
  logic        wr_req, wr_gnt = 1'b0;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req, rd_gnt = 1'b0;
  logic [21:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  arb_state_e  dbg_state;

  sdram_user_port dut (
    .clk(clk), .rst(rst),
    .u_wr_valid(u_wr_valid), .u_wr_ready(u_wr_ready), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
    .u_rd_valid(u_rd_valid), .u_rd_ready(u_rd_ready), .u_rd_addr(u_rd_addr),
    .u_rdata(u_rdata), .u_rdata_valid(u_rdata_valid), .wf_level(wf_level),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- controller responder + scoreboard ----------------
  logic [38:0] log_q[$];
  logic [38:0] exp_q[$];
  bit auto_gnt = 0;
  bit one_wr = 0;
  int gnt_delay = 1;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always @(negedge clk) begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    chk("req_exclusive", wr_req & rd_req, 1'b0);
    if (rst) begin
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (wr_req) wr_cnt++; else wr_cnt = 0;
      if (rd_req) rd_cnt++; else rd_cnt = 0;
      if (wr_req && ((auto_gnt && wr_cnt >= gnt_delay) || one_wr)) begin
        wr_gnt = 1'b1;
        one_wr = 0;
        log_q.push_back({1'b0, wr_addr, wr_data});
      end
      if (rd_req && auto_gnt && rd_cnt >= gnt_delay) begin
        rd_gnt = 1'b1;
        log_q.push_back({1'b1, rd_addr, 16'h0});
      end
    end
  end

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    while (log_q.size() > 0 && exp_q.size() > 0) chk(name, log_q.pop_front(), exp_q.pop_front());
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_log(input int n, input string name);
    int t = 0;
    while (log_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, log_q.size() >= n, 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; auto_gnt = 0; one_wr = 0;
    rd_valid = 1'b0; u_wr_valid = 1'b0; u_rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic push_wr(input logic [21:0] a, input logic [15:0] d, output logic acc);
    @(negedge clk);
    acc = u_wr_ready;
    u_wr_valid = 1'b1; u_wr_addr = a; u_wr_data = d;
    @(posedge clk); #1;
    u_wr_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [21:0] a);
    int t = 0;
    @(negedge clk);
    while (!u_rd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rd_slot_wait", u_rd_ready, 1'b1);
    u_rd_valid = 1'b1; u_rd_addr = a;
    @(posedge clk); #1;
    u_rd_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        is_rd;
    logic [21:0] addr;
    logic [15:0] data;
    logic [7:0]  delay;
    logic [7:0]  exp_hold;
    logic [15:0] exp_rdata;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int t, hold;

    vecs[0] = '{is_rd: 1'b0, addr: 22'h000010, data: 16'hBEEF, delay: 8'd3, exp_hold: 8'd3, exp_rdata: 16'h0};
    vecs[1] = '{is_rd: 1'b0, addr: 22'h3FFFFF, data: 16'hFFFF, delay: 8'd1, exp_hold: 8'd1, exp_rdata: 16'h0};
    vecs[2] = '{is_rd: 1'b1, addr: 22'h123456, data: 16'h0,    delay: 8'd1, exp_hold: 8'd1, exp_rdata: 16'hA5A5};
    vecs[3] = '{is_rd: 1'b1, addr: 22'h3FFFFF, data: 16'h0,    delay: 8'd4, exp_hold: 8'd4, exp_rdata: 16'hFFFF};
    vecs[4] = '{is_rd: 1'b0, addr: 22'h2AAAAA, data: 16'h5555, delay: 8'd2, exp_hold: 8'd2, exp_rdata: 16'h0};
    vecs[5] = '{is_rd: 1'b1, addr: 22'h000001, data: 16'h0,    delay: 8'd2, exp_hold: 8'd2, exp_rdata: 16'h0001};

    // Reset state
    @(negedge clk);
    chk("rst_wr_req", wr_req, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_wr_addr", wr_addr, 22'h0);
    chk("rst_wr_data", wr_data, 16'h0);
    chk("rst_rd_addr", rd_addr, 22'h0);
    chk("rst_rdata", u_rdata, 16'h0);
    chk("rst_rdata_valid", u_rdata_valid, 1'b0);
    chk("rst_level", wf_level, 4'd0);
    chk("rst_wr_ready", u_wr_ready, 1'b1);
    chk("rst_rd_ready", u_rd_ready, 1'b1);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // Single transactions from the table
    for (int i = 0; i < NV; i++) begin
      do_reset();
      auto_gnt = 1;
      gnt_delay = int'(vecs[i].delay);
      if (vecs[i].is_rd) push_rd(vecs[i].addr);
      else begin
        push_wr(vecs[i].addr, vecs[i].data, acc);
        chk("vec_wr_accept", acc, 1'b1);
      end
      @(negedge clk);
      if (vecs[i].is_rd) chk("vec_rd_slot_full", u_rd_ready, 1'b0);
      else chk("vec_level_push", wf_level, 4'd1);
      chk("vec_no_early_req", wr_req | rd_req, 1'b0);
      t = 0;
      while (!(wr_req | rd_req) && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("vec_req_kind", {wr_req, rd_req}, vecs[i].is_rd ? 2'b01 : 2'b10);
      hold = 0;
      while ((wr_req | rd_req) && hold < 60) begin
        hold++;
        chk("vec_addr_stable", vecs[i].is_rd ? rd_addr : wr_addr, vecs[i].addr);
        if (!vecs[i].is_rd) chk("vec_data_stable", wr_data, vecs[i].data);
        @(negedge clk);
      end
      chk("vec_req_hold", hold, vecs[i].exp_hold);
      exp_q.push_back({vecs[i].is_rd, vecs[i].addr, vecs[i].data});
      check_log("vec_issue");
      if (vecs[i].is_rd) begin
        rd_valid = 1'b1;
        rd_data = vecs[i].exp_rdata;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("vec_rdata_valid", u_rdata_valid, 1'b1);
        chk("vec_rdata", u_rdata, vecs[i].exp_rdata);
        @(negedge clk);
        chk("vec_rdata_strobe", u_rdata_valid, 1'b0);
      end else begin
        chk("vec_level_pop", wf_level, 4'd0);
      end
    end

    // FIFO full: 8 accepted, 9th refused, one grant reopens ready, drain keeps order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_wr(22'h100 + 22'(i), 16'hA000 + 16'(i), acc);
      chk("full_fill_accept", acc, 1'b1);
    end
    @(negedge clk);
    chk("full_level", wf_level, 4'd8);
    chk("full_wr_ready", u_wr_ready, 1'b0);
    push_wr(22'h1FF, 16'hDEAD, acc);
    chk("full_9th_refused", acc, 1'b0);
    @(negedge clk);
    chk("full_level_after_9th", wf_level, 4'd8);
    @(posedge clk); #1;
    one_wr = 1;
    @(negedge clk);
    chk("full_level_at_gnt", wf_level, 4'd8);
    @(negedge clk);
    chk("full_level_after_gnt", wf_level, 4'd7);
    chk("full_ready_after_gnt", u_wr_ready, 1'b1);
    gnt_delay = 1;
    auto_gnt = 1;
    wait_log(8, "full_drain_done");
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 22'h100 + 22'(i), 16'hA000 + 16'(i)});
    check_log("full_fifo_order");
    @(negedge clk);
    chk("full_drained_level", wf_level, 4'd0);

    // Interleave: writes and a refilled read alternate W,R,W,R,W,R
    do_reset();
    push_wr(22'h100, 16'h1100, acc);
    push_wr(22'h101, 16'h1101, acc);
    push_wr(22'h102, 16'h1102, acc);
    push_rd(22'h200);
    gnt_delay = 1;
    auto_gnt = 1;
    push_rd(22'h201);
    push_rd(22'h202);
    wait_log(6, "rr_done");
    exp_q.push_back({1'b0, 22'h100, 16'h1100});
    exp_q.push_back({1'b1, 22'h200, 16'h0});
    exp_q.push_back({1'b0, 22'h101, 16'h1101});
    exp_q.push_back({1'b1, 22'h201, 16'h0});
    exp_q.push_back({1'b0, 22'h102, 16'h1102});
    exp_q.push_back({1'b1, 22'h202, 16'h0});
    check_log("rr_order");

    // Watermark: level 6 after a write grant still issues a write; level 5 lets the read in
    do_reset();
    for (int i = 0; i < 7; i++) push_wr(22'h300 + 22'(i), 16'h3000 + 16'(i), acc);
    push_rd(22'h400);
    gnt_delay = 1;
    auto_gnt = 1;
    wait_log(8, "wm_done");
    exp_q.push_back({1'b0, 22'h300, 16'h3000});
    exp_q.push_back({1'b0, 22'h301, 16'h3001});
    exp_q.push_back({1'b1, 22'h400, 16'h0});
    for (int i = 2; i < 7; i++) exp_q.push_back({1'b0, 22'h300 + 22'(i), 16'h3000 + 16'(i)});
    check_log("wm_order");

    // Outstanding limit: four reads granted, fifth waits for a return
    do_reset();
    gnt_delay = 1;
    auto_gnt = 1;
    for (int i = 0; i < 5; i++) push_rd(22'h500 + 22'(i));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lim_no_5th_req", rd_req, 1'b0);
    end
    chk("lim_slot_held", u_rd_ready, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 22'h500 + 22'(i), 16'h0});
    check_log("lim_first4");
    rd_valid = 1'b1;
    rd_data = 16'h1234;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("lim_rdata_valid", u_rdata_valid, 1'b1);
    chk("lim_rdata", u_rdata, 16'h1234);
    wait_log(1, "lim_5th_issued");
    exp_q.push_back({1'b1, 22'h504, 16'h0});
    check_log("lim_5th");

    // Reset while a write request is pending
    do_reset();
    push_wr(22'h600, 16'h6666, acc);
    push_wr(22'h601, 16'h6667, acc);
    push_rd(22'h700);
    @(negedge clk);
    chk("rstmid_wr_req_before", wr_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wr_req", wr_req, 1'b0);
    chk("rstmid_rd_req", rd_req, 1'b0);
    chk("rstmid_level", wf_level, 4'd0);
    chk("rstmid_wr_ready", u_wr_ready, 1'b1);
    chk("rstmid_rd_ready", u_rd_ready, 1'b1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_quiet", wr_req | rd_req, 1'b0);
    chk("rstmid_no_issue", log_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
